pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor.sv | 122 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Sequences a PLL out of reset and holds the logic it clocks in reset
//   until lock has been continuously stable. A lost lock in RUN or a
//   WAIT_LOCK timeout restarts the sequence with a fresh PLL reset pulse.
//   Runs entirely on the reference clock.
//
// Ports
//   clkin            reference clock
//   reset            asynchronous active-high reset
//   lock_i           PLL LOCK, asynchronous to clkin
//   pll_reset_o      PLL RESET, high while in PLL_RST
//   sys_reset_o      reset for PLL-clocked logic, low only in RUN
//   locked_o         high only in RUN
//   relock_count_o   lock losses seen in RUN (saturates at 255)
//   timeout_count_o  WAIT_LOCK timeouts (saturates at 255)
module pll_lock_supervisor #(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1000,
  parameter int LOCK_TIMEOUT_CYCLES = 100000
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock_i,
  output logic       pll_reset_o,
  output logic       sys_reset_o,
  output logic       locked_o,
  output logic [7:0] relock_count_o,
  output logic [7:0] timeout_count_o
);

  localparam int MAX_AB  = (PLL_RESET_CYCLES > LOCK_STABLE_CYCLES) ?
                           PLL_RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    PLL_RST    = 2'd0,
    WAIT_LOCK  = 2'd1,
    STABLE_CHK = 2'd2,
    RUN        = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             lock_p0, lock_s;
  logic             relock_inc, timeout_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0/s: two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      lock_p0 <= lock_i;
      lock_s  <= lock_p0;
    end
  end

  // State, shared cycle counter and saturating event counters
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state           <= PLL_RST;
      cnt             <= '0;
      relock_count_o  <= 8'd0;
      timeout_count_o <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (relock_inc)  relock_count_o  <= sat_inc(relock_count_o);
      if (timeout_inc) timeout_count_o <= sat_inc(timeout_count_o);
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt + CNT_W'(1);
    relock_inc  = 1'b0;
    timeout_inc = 1'b0;
    case (state)
      // lock_s is deliberately ignored here so the reset pulse always completes
      PLL_RST: begin
        if (cnt == RST_LAST) state_next = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = STABLE_CHK;
        end else if (cnt == TO_LAST) begin
          state_next  = PLL_RST;
          timeout_inc = 1'b1;
        end
      end
      // A drop seen on the terminal-count edge wins over the RUN transition
      STABLE_CHK: begin
        if (!lock_s)               state_next = WAIT_LOCK;
        else if (cnt == STB_LAST)  state_next = RUN;
      end
      RUN: begin
        cnt_next = '0;
        if (!lock_s) begin
          state_next = PLL_RST;
          relock_inc = 1'b1;
        end
      end
      default: state_next = PLL_RST;
    endcase
    if (state_next != state) cnt_next = '0;
  end

  // Outputs decode the state register only; no path from lock_i
  assign pll_reset_o = (state == PLL_RST);
  assign sys_reset_o = (state != RUN);
  assign locked_o    = (state == RUN);

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       lock_i = 1'b0;
  logic       pll_reset_o, sys_reset_o, locked_o;
  logic [7:0] relock_count_o, timeout_count_o;

  pll_lock_supervisor #(
    .PLL_RESET_CYCLES   (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32)
  ) dut (
    .clkin          (clkin),
    .reset          (reset),
    .lock_i         (lock_i),
    .pll_reset_o    (pll_reset_o),
    .sys_reset_o    (sys_reset_o),
    .locked_o       (locked_o),
    .relock_count_o (relock_count_o),
    .timeout_count_o(timeout_count_o)
  );

  always #5 clkin = ~clkin;

  // One record per clock edge: lock_i driven before the edge and the
  // expected {pll_reset_o, sys_reset_o, locked_o} after it.
  typedef struct {
    logic       lock;
    logic [2:0] exp;
  } vec_t;

  vec_t vecs[64];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  function automatic logic [2:0] outs();
    return {pll_reset_o, sys_reset_o, locked_o};
  endfunction

  // Reset held across two edges, released mid-cycle; then the reset state is checked
  task automatic do_reset(input logic lv);
    reset  = 1'b1;
    lock_i = lv;
    repeat (2) @(posedge clkin);
    #3;
    reset = 1'b0;
    #1;
    chk("reset_outs", 16'(outs()), 16'(3'b110));
    chk("reset_cnts", {relock_count_o, timeout_count_o}, 16'h0000);
  endtask

  task automatic run_table(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      lock_i = vecs[i].lock;
      tick();
      chk($sformatf("%s_edge%0d", nm, i + 1), 16'(outs()), 16'(vecs[i].exp));
    end
  endtask

  initial begin
    // Clean lock: lock_i rises after edge 10, first sampled at edge 11,
    // release 10 edges later at edge 21. Pulse covers edges 1-3.
    do_reset(1'b0);
    for (int k = 1; k <= 22; k++) begin
      vecs[k-1].lock = (k >= 11);
      vecs[k-1].exp  = {k < 4, k < 21, k >= 21};
    end
    run_table(22, "clean");
    chk("clean_relock", 16'(relock_count_o), 16'd0);
    chk("clean_timeout", 16'(timeout_count_o), 16'd0);

    // Loss in RUN: lock_i low for edges 1-3; FSM sees lock_s=0 at edge 3,
    // pulses PLL reset for edges 3-6, STABLE_CHK from edge 8, RUN at edge 16.
    for (int k = 1; k <= 18; k++) begin
      vecs[k-1].lock = !(k <= 3);
      vecs[k-1].exp  = {(k >= 3 && k <= 6), !(k < 3 || k >= 16), (k < 3 || k >= 16)};
    end
    run_table(18, "loss");
    chk("loss_relock", 16'(relock_count_o), 16'd1);
    chk("loss_timeout", 16'(timeout_count_o), 16'd0);

    // Asynchronous reset between edges while in RUN
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_outs", 16'(outs()), 16'(3'b110));
    chk("async_rst_cnts", {relock_count_o, timeout_count_o}, 16'h0000);

    // Lock high throughout PLL_RST (ignored), STABLE_CHK from edge 5;
    // 1-cycle glitch sampled at edge 9, high re-sampled at edge 10,
    // back to WAIT_LOCK at edge 11, release at edge 20.
    do_reset(1'b1);
    for (int k = 1; k <= 22; k++) begin
      vecs[k-1].lock = (k != 9);
      vecs[k-1].exp  = {k < 4, k < 20, k >= 20};
    end
    run_table(22, "glitch");
    chk("glitch_relock", 16'(relock_count_o), 16'd0);

    // Boundary: lock_s goes 0 on the edge that sees count 7 (edge 13),
    // so the FSM falls back to WAIT_LOCK and never releases.
    do_reset(1'b1);
    for (int k = 1; k <= 24; k++) begin
      vecs[k-1].lock = (k <= 10);
      vecs[k-1].exp  = {k < 4, 1'b1, 1'b0};
    end
    run_table(24, "boundary");

    // Timeout: lock_i held low, 32 WAIT_LOCK cycles then a 4-cycle pulse,
    // count saturating at 255.
    do_reset(1'b0);
    repeat (4) tick();
    chk("to_wait_entry", 16'(outs()), 16'(3'b010));
    for (int r = 1; r <= 258; r++) begin
      repeat (31) tick();
      chk($sformatf("to_wait_r%0d", r), 16'(pll_reset_o), 16'd0);
      tick();
      chk($sformatf("to_pulse_r%0d", r), 16'(pll_reset_o), 16'd1);
      chk($sformatf("to_count_r%0d", r), 16'(timeout_count_o), 16'((r > 255) ? 255 : r));
      repeat (3) tick();
      chk($sformatf("to_pulse_end_r%0d", r), 16'(pll_reset_o), 16'd1);
      tick();
      chk($sformatf("to_after_r%0d", r), 16'(pll_reset_o), 16'd0);
    end
    chk("to_relock", 16'(relock_count_o), 16'd0);
    chk("to_never_locked", 16'(locked_o), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
